// File: rtl/request_responder_pkg.sv
// Shared types and defaults for the request_begin/request_end responder.
// The FSM state type is exported so checkers can observe the state through the debug port.
package request_pkg;

  typedef enum logic [1:0] {
    RSP_IDLE    = 2'd0,
    RSP_ISSUE   = 2'd1,
    RSP_WAIT    = 2'd2,
    RSP_RESPOND = 2'd3
  } rsp_state_t;

  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_DEPTH          = 4;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/request_responder_if.sv
// Memory-side port of the responder: request offer plus completion return.
// Handshake: a request transfers on a posedge where mem_valid & mem_ready are both 1.
// While mem_valid is high, mem_addr/mem_wdata/mem_write stay stable until that edge.
// mem_done is a one-cycle completion pulse, and mem_rdata is meaningful only while it is high.
interface request_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_write;
  logic                  mem_done;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_write,
    input  mem_ready,
    input  mem_done,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_write,
    output mem_ready,
    output mem_done,
    output mem_rdata
  );

endinterface

// File: rtl/request_responder_fifo.sv
// Request queue for the responder: power-of-2 circular buffer with a registered count.
// A push is accepted when the queue is full only if a pop happens in the same cycle.
module request_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_en;
  logic             pop_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage is not reset; the top only exposes head while a request is offered.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/request_responder.sv
// Responder end of the request_begin/request_end protocol: queues requests, issues them one at a
// time to the memory port, and returns exactly one in-order request_end per accepted request.
module request_responder
  import request_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  request_begin,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_write,
  output logic                  req_full,
  output logic                  overflow,
  output logic                  request_end,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_error,
  output logic                  busy,
  request_responder_if.master   mem,
  output rsp_state_t            dbg_state
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  rsp_state_t            state_q;
  rsp_state_t            state_d;
  logic [TW-1:0]         cnt_q;
  logic                  timeout_hit;
  logic                  wr_inflight_q;
  logic                  overflow_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic                  resp_error_q;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [EW-1:0]         fifo_head;
  logic                  head_write;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;

  // Queue entry layout: {write, addr, wdata}.
  assign fifo_push  = request_begin & (~fifo_full | fifo_pop);
  assign head_write = fifo_head[EW-1];
  assign head_addr  = fifo_head[EW-2 -: ADDR_WIDTH];
  assign head_wdata = fifo_head[DATA_WIDTH-1:0];

  request_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data ({req_write, req_addr, req_wdata}),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign timeout_hit = (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RSP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      RSP_IDLE: begin
        if (!fifo_empty) begin
          state_d = RSP_ISSUE;
        end
      end
      RSP_ISSUE: begin
        if (mem.mem_ready) begin
          fifo_pop = 1'b1;
          state_d  = RSP_WAIT;
        end
      end
      RSP_WAIT: begin
        // A completion arriving on the last timeout cycle still counts as a normal completion.
        if (mem.mem_done || timeout_hit) begin
          state_d = RSP_RESPOND;
        end
      end
      RSP_RESPOND: begin
        state_d = fifo_empty ? RSP_IDLE : RSP_ISSUE;
      end
      default: state_d = RSP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      wr_inflight_q <= 1'b0;
      overflow_q    <= 1'b0;
      resp_data_q   <= '0;
      resp_error_q  <= 1'b0;
    end else begin
      overflow_q <= overflow_q | (request_begin & ~fifo_push);
      case (state_q)
        RSP_ISSUE: begin
          if (mem.mem_ready) begin
            cnt_q         <= '0;
            wr_inflight_q <= head_write;
          end
        end
        RSP_WAIT: begin
          if (mem.mem_done) begin
            resp_data_q  <= wr_inflight_q ? '0 : mem.mem_rdata;
            resp_error_q <= 1'b0;
          end else if (timeout_hit) begin
            resp_data_q  <= '0;
            resp_error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Head fields are only driven while offered, so the port reads all-zero when idle.
  assign mem.mem_valid = (state_q == RSP_ISSUE);
  assign mem.mem_addr  = mem.mem_valid ? head_addr  : '0;
  assign mem.mem_wdata = mem.mem_valid ? head_wdata : '0;
  assign mem.mem_write = mem.mem_valid & head_write;

  assign request_end = (state_q == RSP_RESPOND);
  assign resp_data   = resp_data_q;
  assign resp_error  = resp_error_q;
  assign req_full    = fifo_full;
  assign overflow    = overflow_q;
  assign busy        = (fifo_count != '0) || (state_q != RSP_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_request_responder.sv
// Directed bench for request_responder: expected completions are queued at stimulus time and a
// monitor checks each request_end against the queue head.
module tb_request_responder;
  import request_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TO    = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          request_begin = 1'b0;
  logic [AW-1:0] req_addr      = '0;
  logic [DW-1:0] req_wdata     = '0;
  logic          req_write     = 1'b0;
  logic          req_full;
  logic          overflow;
  logic          request_end;
  logic [DW-1:0] resp_data;
  logic          resp_error;
  logic          busy;
  rsp_state_t    dbg_state;

  request_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  request_responder #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .request_begin (request_begin),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_write     (req_write),
    .req_full      (req_full),
    .overflow      (overflow),
    .request_end   (request_end),
    .resp_data     (resp_data),
    .resp_error    (resp_error),
    .busy          (busy),
    .mem           (mem_if.master),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [DW:0]   exp_q[$];   // {resp_error, resp_data}
  logic [DW-1:0] rd_q[$];    // read data the backend returns, in order
  logic [DW:0]   mon_exp;
  bit            auto_done = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset && request_end) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_end: request_end with nothing pending (cycle %0d)", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        check("resp", {31'd0, resp_error, resp_data}, {31'd0, mon_exp});
      end
    end
  end

  // ---------------- backend model ----------------
  initial begin
    mem_if.mem_ready = 1'b0;
    mem_if.mem_done  = 1'b0;
    mem_if.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (auto_done && reset && mem_if.mem_valid && mem_if.mem_ready) begin
        @(posedge clk); #1;
        mem_if.mem_done = 1'b1;
        if (rd_q.size() > 0) mem_if.mem_rdata = rd_q.pop_front();
        else                 mem_if.mem_rdata = '0;
        @(posedge clk); #1;
        mem_if.mem_done  = 1'b0;
        mem_if.mem_rdata = '0;
      end
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic push_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    request_begin = 1'b1;
    req_addr      = a;
    req_wdata     = d;
    req_write     = w;
    @(posedge clk); #1;
    request_begin = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    req_write     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_mem_valid", mem_if.mem_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_request_end", request_end, 0);
    request_begin    = 1'b0;
    auto_done        = 1'b0;
    mem_if.mem_ready = 1'b0;
    mem_if.mem_done  = 1'b0;
    mem_if.mem_rdata = '0;
    exp_q.delete();
    rd_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check("rst_req_full", req_full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_resp", {resp_error, resp_data}, 0);
    check("rst_state", dbg_state, RSP_IDLE);
  endtask

  // Ends on a negedge.
  task automatic wait_state(input rsp_state_t s, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dbg_state != s && n < 40);
    check(name, dbg_state, s);
  endtask

  // Ends on a negedge.
  task automatic wait_end(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!request_end && n < 40);
    check(name, request_end, 1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check({name, "_idle"}, busy, 0);
  endtask

  // ---------------- directed tests ----------------
  int unsigned c0;

  initial begin
    #2;
    do_reset();

    // 1: single read, fixed latency E0 -> request_end after E3
    mem_if.mem_ready = 1'b1;
    auto_done        = 1'b1;
    rd_q.push_back(32'hDEADBEEF);
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    c0 = cyc;
    push_req(32'h0000_0100, 32'h0, 1'b0);
    wait_end("t1_end");
    check("t1_latency", cyc - c0, 4);
    @(posedge clk); #1;
    wait_drain("t1", 50);

    // 2: five back-to-back pushes with the backend stalled
    mem_if.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_req(32'h10 + i, 32'h0, 1'b0);
      if (i == 3) begin
        check("t2_full_after4", req_full, 1);
        check("t2_no_ovf_after4", overflow, 0);
      end
    end
    check("t2_overflow", overflow, 1);
    check("t2_full", req_full, 1);
    check("t2_mem_valid", mem_if.mem_valid, 1);
    check("t2_mem_addr", mem_if.mem_addr, 32'h10);
    check("t2_mem_write", mem_if.mem_write, 0);
    for (int i = 0; i < 4; i++) begin
      rd_q.push_back(32'hA000_0001 + i);
      exp_q.push_back({1'b0, 32'hA000_0001 + i});
    end
    mem_if.mem_ready = 1'b1;
    wait_drain("t2", 200);
    check("t2_overflow_sticky", overflow, 1);
    do_reset();

    // 4: push while full, on the same edge as the issue handshake pop
    auto_done = 1'b1;
    rd_q.push_back(32'hB000_0001); exp_q.push_back({1'b0, 32'hB000_0001});
    rd_q.push_back(32'hFFFF_FFFF); exp_q.push_back({1'b0, 32'h0});
    rd_q.push_back(32'hB000_0003); exp_q.push_back({1'b0, 32'hB000_0003});
    rd_q.push_back(32'hFFFF_FFFF); exp_q.push_back({1'b0, 32'h0});
    rd_q.push_back(32'hB000_0005); exp_q.push_back({1'b0, 32'hB000_0005});
    push_req(32'h20, 32'h0, 1'b0);
    push_req(32'h21, 32'h55, 1'b1);
    push_req(32'h22, 32'h0, 1'b0);
    push_req(32'h23, 32'h66, 1'b1);
    check("t4_full_before", req_full, 1);
    mem_if.mem_ready = 1'b1;
    push_req(32'h24, 32'h0, 1'b0);
    check("t4_full_after", req_full, 1);
    check("t4_no_overflow", overflow, 0);
    check("t4_state_wait", dbg_state, RSP_WAIT);
    wait_drain("t4", 200);

    // 3: timeout with no completion, then a late done is ignored
    auto_done = 1'b0;
    exp_q.push_back({1'b1, 32'h0});
    push_req(32'h30, 32'h0, 1'b0);
    wait_state(RSP_WAIT, "t3_reach_wait");
    c0 = cyc;
    wait_end("t3_end");
    check("t3_timeout_cycles", cyc - c0, TO);
    repeat (2) @(posedge clk);
    #1;
    mem_if.mem_done  = 1'b1;
    mem_if.mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_if.mem_done  = 1'b0;
    mem_if.mem_rdata = '0;
    repeat (5) @(posedge clk);
    #1;
    check("t3_resp_held", {resp_error, resp_data}, {1'b1, 32'h0});
    wait_drain("t3", 20);

    // 6: completion on the same cycle the timeout would fire
    exp_q.push_back({1'b0, 32'hC0DE_F00D});
    push_req(32'h40, 32'h0, 1'b0);
    wait_state(RSP_WAIT, "t6_reach_wait");
    repeat (TO - 1) @(posedge clk);
    #1;
    mem_if.mem_done  = 1'b1;
    mem_if.mem_rdata = 32'hC0DE_F00D;
    @(posedge clk); #1;
    mem_if.mem_done  = 1'b0;
    mem_if.mem_rdata = '0;
    wait_drain("t6", 20);

    // 5: reset while waiting with two entries still queued
    push_req(32'h50, 32'h0, 1'b0);
    push_req(32'h51, 32'h0, 1'b0);
    push_req(32'h52, 32'h0, 1'b0);
    wait_state(RSP_WAIT, "t5_reach_wait");
    check("t5_busy_before", busy, 1);
    #1;
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    check("t5_idle_after", busy, 0);

    // 5b: reset while a request is being offered drops mem_valid at once
    push_req(32'h60, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("t5b_offering", mem_if.mem_valid, 1);
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
